// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, programmable almost-full/empty
// thresholds, sticky overflow/underflow flags and an optional first-word-fall-through read port.
module sync_fifo_param #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 32,
    parameter int AF_THRESH = 28,
    parameter int AE_THRESH = 4,
    parameter int FWFT      = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       rd_en,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow,
    input  logic                       clr_err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] AF_LVL = (AW+1)'(AF_THRESH);
    localparam logic [AW:0] AE_LVL = (AW+1)'(AE_THRESH);

    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("sync_fifo_param: DEPTH must be a power of 2 and >= 4");
    end
    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
        $error("sync_fifo_param: AF_THRESH must be in 1..DEPTH");
    end
    if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
        $error("sync_fifo_param: AE_THRESH must be in 0..DEPTH-1");
    end

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic              wr_acc;
    logic              rd_acc;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign count        = wr_ptr - rd_ptr;
    assign full         = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty        = (wr_ptr == rd_ptr);
    assign almost_full  = (count >= AF_LVL);
    assign almost_empty = (count <= AE_LVL);

    assign wr_acc = wr_en && !full;
    assign rd_acc = rd_en && !empty;

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage is never cleared; reset only forgets it by rewinding the pointers.
    always_ff @(posedge clk) begin
        if (rst && wr_acc) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    // Error flags: a new error event outranks a simultaneous clear.
    always_ff @(posedge clk) begin
        if (!rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en && full)      overflow <= 1'b1;
            else if (clr_err)       overflow <= 1'b0;
            if (rd_en && empty)     underflow <= 1'b1;
            else if (clr_err)       underflow <= 1'b0;
        end
    end

    if (FWFT != 0) begin : g_fwft
        assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];
    end else begin : g_std
        logic [DATA_W-1:0] rd_q;
        always_ff @(posedge clk) begin
            if (!rst)        rd_q <= '0;
            else if (rd_acc) rd_q <= mem[rd_ptr[AW-1:0]];
        end
        assign rd_data = rd_q;
    end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param: table vectors, a queue scoreboard with
// reference model for the standard-read instance, and a short FWFT sequence.
module tb_sync_fifo_param;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       rd_en;
    logic       clr_err;
    logic [7:0] rd_data;
    logic       full, empty, almost_full, almost_empty, overflow, underflow;
    logic [5:0] count;

    logic       f_rst, f_wr_en, f_rd_en, f_clr_err;
    logic [7:0] f_wr_data, f_rd_data;
    logic       f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
    logic [5:0] f_count;

    sync_fifo_param #(.DATA_W(8), .DEPTH(32), .AF_THRESH(28), .AE_THRESH(4), .FWFT(0)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(rd_data), .full(full), .empty(empty), .almost_full(almost_full),
        .almost_empty(almost_empty), .count(count), .overflow(overflow),
        .underflow(underflow), .clr_err(clr_err)
    );

    sync_fifo_param #(.DATA_W(8), .DEPTH(32), .AF_THRESH(28), .AE_THRESH(4), .FWFT(1)) dut_f (
        .clk(clk), .rst(f_rst), .wr_en(f_wr_en), .wr_data(f_wr_data), .rd_en(f_rd_en),
        .rd_data(f_rd_data), .full(f_full), .empty(f_empty), .almost_full(f_af),
        .almost_empty(f_ae), .count(f_count), .overflow(f_ovf),
        .underflow(f_unf), .clr_err(f_clr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [7:0] sb[$];
    int         m_count = 0;
    logic       m_ovf = 1'b0;
    logic       m_unf = 1'b0;
    logic [7:0] m_rd = 8'h00;
    int         max_count = 0;

    typedef struct {
        logic       rst;
        logic       we;
        logic [7:0] wd;
        logic       re;
        logic       ce;
        logic [5:0] cnt;
        logic       full;
        logic       empty;
        logic       af;
        logic       ae;
        logic       ovf;
        logic       unf;
        logic [7:0] rd;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle on the standard instance, advance the model, compare all outputs.
    task automatic step(input logic r, input logic we, input logic [7:0] wd,
                        input logic re, input logic ce);
        logic wacc, racc;
        rst = r; wr_en = we; wr_data = wd; rd_en = re; clr_err = ce;
        @(posedge clk);
        #1;
        if (!r) begin
            sb.delete();
            m_count = 0; m_ovf = 1'b0; m_unf = 1'b0; m_rd = 8'h00;
        end else begin
            wacc = we && (m_count < 32);
            racc = re && (m_count > 0);
            if (we && m_count == 32) m_ovf = 1'b1;
            else if (ce)             m_ovf = 1'b0;
            if (re && m_count == 0)  m_unf = 1'b1;
            else if (ce)             m_unf = 1'b0;
            if (racc) m_rd = sb.pop_front();
            if (wacc) sb.push_back(wd);
            m_count = m_count + int'(wacc) - int'(racc);
        end
        if (m_count > max_count) max_count = m_count;
        chk("count", 32'(count), 32'(m_count));
        chk("full", 32'(full), 32'(m_count == 32));
        chk("empty", 32'(empty), 32'(m_count == 0));
        chk("almost_full", 32'(almost_full), 32'(m_count >= 28));
        chk("almost_empty", 32'(almost_empty), 32'(m_count <= 4));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("underflow", 32'(underflow), 32'(m_unf));
        chk("rd_data", 32'(rd_data), 32'(m_rd));
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
    endtask

    initial begin
        rst = 1'b0; wr_en = 1'b0; wr_data = 8'h00; rd_en = 1'b0; clr_err = 1'b0;
        f_rst = 1'b0; f_wr_en = 1'b0; f_wr_data = 8'h00; f_rd_en = 1'b0; f_clr_err = 1'b0;

        //          rst   we    wd     re    ce    cnt    full  empty af    ae    ovf   unf   rd
        tbl[0]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 6'd0,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        tbl[1]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 6'd0,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00};
        tbl[2]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 6'd0,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        tbl[3]  = '{1'b1, 1'b1, 8'h11, 1'b0, 1'b0, 6'd1,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        tbl[4]  = '{1'b1, 1'b1, 8'h22, 1'b0, 1'b0, 6'd2,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        tbl[5]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 6'd1,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h11};
        tbl[6]  = '{1'b1, 1'b1, 8'h33, 1'b1, 1'b0, 6'd1,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h22};
        tbl[7]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 6'd0,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h33};
        tbl[8]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 6'd0,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h33};
        tbl[9]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 6'd0,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h33};
        tbl[10] = '{1'b1, 1'b1, 8'h44, 1'b1, 1'b0, 6'd1,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h33};
        tbl[11] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 6'd0,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};

        @(posedge clk);
        #1;
        for (int i = 0; i < 12; i++) begin
            step(tbl[i].rst, tbl[i].we, tbl[i].wd, tbl[i].re, tbl[i].ce);
            chk($sformatf("vec%0d_count", i), 32'(count), 32'(tbl[i].cnt));
            chk($sformatf("vec%0d_full", i), 32'(full), 32'(tbl[i].full));
            chk($sformatf("vec%0d_empty", i), 32'(empty), 32'(tbl[i].empty));
            chk($sformatf("vec%0d_af", i), 32'(almost_full), 32'(tbl[i].af));
            chk($sformatf("vec%0d_ae", i), 32'(almost_empty), 32'(tbl[i].ae));
            chk($sformatf("vec%0d_ovf", i), 32'(overflow), 32'(tbl[i].ovf));
            chk($sformatf("vec%0d_unf", i), 32'(underflow), 32'(tbl[i].unf));
            chk($sformatf("vec%0d_rd", i), 32'(rd_data), 32'(tbl[i].rd));
        end

        // Fill with 0x00..0x1F, then one write into a full FIFO
        for (int i = 0; i < 32; i++) begin
            step(1'b1, 1'b1, 8'(i), 1'b0, 1'b0);
            if (i == 4) chk("fill_ae_at5", 32'(almost_empty), 32'd0);
            if (i == 3) chk("fill_ae_at4", 32'(almost_empty), 32'd1);
            if (i == 26) chk("fill_af_at27", 32'(almost_full), 32'd0);
            if (i == 27) chk("fill_af_at28", 32'(almost_full), 32'd1);
        end
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_count", 32'(count), 32'd32);
        step(1'b1, 1'b1, 8'hAA, 1'b0, 1'b0);
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("ovf_count", 32'(count), 32'd32);

        // Drain in order
        for (int i = 0; i < 32; i++) begin
            step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
            chk("drain_word", 32'(rd_data), 32'(i));
        end
        chk("drain_empty", 32'(empty), 32'd1);
        step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("unf_set", 32'(underflow), 32'd1);
        chk("unf_hold", 32'(rd_data), 32'h1F);
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        chk("clr_ovf", 32'(overflow), 32'd0);
        chk("clr_unf", 32'(underflow), 32'd0);

        // Wrap-around: 3 writes then 2 reads, random data
        max_count = 0;
        for (int c = 0; c < 100; c++) begin
            if ((c % 5) < 3) step(1'b1, 1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
            else             step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        end
        chk("wrap_max_count_le32", 32'(max_count <= 32), 32'd1);
        chk("wrap_count", 32'(count), 32'd20);

        // Simultaneous read/write at count 16
        while (m_count > 16) step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        for (int c = 0; c < 10; c++) begin
            step(1'b1, 1'b1, 8'($urandom_range(0, 255)), 1'b1, 1'b0);
            chk("simul_count16", 32'(count), 32'd16);
        end
        while (m_count < 32) step(1'b1, 1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'hEE, 1'b1, 1'b0);
        chk("full_simul_count", 32'(count), 32'd31);
        chk("full_simul_ovf", 32'(overflow), 32'd1);

        // Mid-operation reset at count 10
        while (m_count > 10) step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("pre_rst_count", 32'(count), 32'd10);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("mrst_count", 32'(count), 32'd0);
        chk("mrst_empty", 32'(empty), 32'd1);
        chk("mrst_ovf", 32'(overflow), 32'd0);
        chk("mrst_unf", 32'(underflow), 32'd0);
        chk("mrst_rd", 32'(rd_data), 32'd0);
        step(1'b1, 1'b1, 8'h33, 1'b0, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("mrst_first_read", 32'(rd_data), 32'h33);

        // FWFT instance
        f_rst = 1'b0;
        @(posedge clk);
        #1;
        f_rst = 1'b1;
        chk("fwft_rst_empty", 32'(f_empty), 32'd1);
        chk("fwft_rst_rd", 32'(f_rd_data), 32'd0);
        chk("fwft_rst_count", 32'(f_count), 32'd0);
        f_wr_en = 1'b1; f_wr_data = 8'h5A;
        @(posedge clk);
        #1;
        f_wr_en = 1'b0;
        chk("fwft_empty_after_wr", 32'(f_empty), 32'd0);
        chk("fwft_head", 32'(f_rd_data), 32'h5A);
        @(posedge clk);
        #1;
        chk("fwft_head_hold", 32'(f_rd_data), 32'h5A);
        f_rd_en = 1'b1;
        @(posedge clk);
        #1;
        f_rd_en = 1'b0;
        chk("fwft_consumed_empty", 32'(f_empty), 32'd1);
        chk("fwft_consumed_rd", 32'(f_rd_data), 32'd0);
        f_wr_en = 1'b1; f_wr_data = 8'hA1;
        @(posedge clk);
        #1;
        f_wr_data = 8'hB2;
        @(posedge clk);
        #1;
        f_wr_en = 1'b0;
        chk("fwft_two_head", 32'(f_rd_data), 32'hA1);
        f_rd_en = 1'b1;
        @(posedge clk);
        #1;
        f_rd_en = 1'b0;
        chk("fwft_next_head", 32'(f_rd_data), 32'hB2);
        chk("fwft_count", 32'(f_count), 32'd1);
        chk("fwft_flags", 32'({f_full, f_af, f_ae, f_ovf, f_unf}), 32'b00100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
Parametrised single-clock synchronous FIFO, the next-generation replacement for the fixed 8x32 FIFO.
- Width and depth are configurable.
- Adds an occupancy count, programmable almost-full and almost-empty flags, sticky overflow and underflow error flags, and an optional first-word-fall-through (FWFT) read mode.
- Sits between producer and consumer datapaths in the same clock domain.

Parameters:
DATA_W, 8, data word width in bits (>=1)
DEPTH, 32, number of entries; power of 2, >=4; AW = log2(DEPTH)
AF_THRESH, 28, almost_full asserts when count >= AF_THRESH; legal 1..DEPTH
AE_THRESH, 4, almost_empty asserts when count <= AE_THRESH; legal 0..DEPTH-1
FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  reset, synchronous, active-low
wr_en  input  1  write request
wr_data  input  DATA_W  write data
rd_en  input  1  read request
rd_data  output  DATA_W  read data
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= AF_THRESH
almost_empty  output  1  count <= AE_THRESH
count  output  AW+1  current occupancy, 0..DEPTH
overflow  output  1  sticky: a write was attempted while full
underflow  output  1  sticky: a read was attempted while empty
clr_err  input  1  clears overflow and underflow

Behaviour:
- Pointers: wr_ptr and rd_ptr are AW+1 bits each. Memory is indexed by [AW-1:0]. Pointers wrap naturally modulo 2*DEPTH.
- Status derivation:
  - count = wr_ptr - rd_ptr, computed modulo 2^(AW+1).
  - full = (MSBs differ) && (lower AW bits equal).
  - empty = (wr_ptr == rd_ptr).
  - All status outputs are combinational from registered pointers. They change only on the clock edge that updates the pointers.
- Reset, taken when rst == 0 at posedge:
  - wr_ptr = rd_ptr = 0; overflow = underflow = 0; rd_data = 0.
  - Resulting outputs: empty=1, full=0, count=0, almost_empty=1, almost_full=0 (AF_THRESH >= 1).
  - Memory contents are not cleared.
  - Reset mid-operation discards all stored data; the first read after reset returns the first post-reset write.
  - Reset has priority over all other inputs.
- Write acceptance: wr_acc = wr_en && !full. On acceptance: mem[wr_ptr] <= wr_data and wr_ptr+1.
  - wr_en && full: data dropped, wr_ptr unchanged, overflow <= 1.
- Read acceptance: rd_acc = rd_en && !empty.
  - rd_en && empty: rd_ptr unchanged, rd_data holds its value, underflow <= 1.
- Simultaneous wr_acc and rd_acc: both pointers advance and count is unchanged.
  - When full, only the read is accepted (write rejected, overflow set).
  - When empty, only the write is accepted (read rejected, underflow set).
  - No same-cycle bypass.
- FWFT=0 (standard read):
  - On rd_acc, rd_data <= mem[rd_ptr[AW-1:0]]. Valid from the cycle after the accepting edge (1-cycle latency).
  - rd_data holds when no read is accepted.
- FWFT=1 (first-word-fall-through):
  - rd_data = mem[rd_ptr[AW-1:0]] whenever !empty, else forced to 0.
  - The head word is visible in the cycle after it is written into an empty FIFO (same cycle empty deasserts).
  - rd_en && !empty consumes the displayed word; the next word appears after that edge.
- Error flags:
  - overflow and underflow stay set until clr_err is sampled high; they clear at that edge.
  - If an error event and clr_err occur in the same cycle, set wins (flag stays 1).
- Threshold flags are evaluated on count with unsigned comparison. Both almost_full and almost_empty may be high simultaneously if thresholds overlap; this is legal.
- Parameter checks: illegal DEPTH, AF_THRESH or AE_THRESH values cause an elaboration-time error (generate-block $error).

Test Plan:
1. Reset then fill (defaults, FWFT=0): release rst, write 0x00..0x1F on 32 consecutive cycles.
   - almost_empty drops after count reaches 5.
   - almost_full rises when count reaches 28.
   - full=1, count=32 after the 32nd write.
   - A 33rd write of 0xAA sets overflow; the FIFO contents are unchanged.
2. Drain: 32 consecutive reads return 0x00..0x1F in order, each 1 cycle after its accepting edge.
   - empty=1 after the last read.
   - A further rd_en sets underflow; rd_data holds 0x1F.
   - clr_err clears both flags on the next edge.
3. Wrap-around: run 100 cycles of a 3-writes/2-reads pattern with random data.
   - The scoreboard matches throughout.
   - count never exceeds 32.
   - Pointers pass index 31->0 and MSB toggles with no data loss.
4. Simultaneous read/write at count=16: wr_en and rd_en high together for 10 cycles.
   - count stays 16; data order is preserved.
   - At full, simultaneous rd_en+wr_en gives count=31 and overflow=1.
5. FWFT=1: write 0x5A into an empty FIFO.
   - Next cycle: empty=0, rd_data=0x5A with no rd_en.
   - rd_en consumes it: empty=1, rd_data=0.
6. Mid-operation reset with count=10: assert rst for 1 cycle.
   - Result: count=0, empty=1, overflow=underflow=0, rd_data=0.
   - Next write 0x33 then read returns 0x33.
